pixel_readout_receiver: RTL and testbench

- Receiving end of the pixel array readout bus.
- Samples DATA_OUT_CLK/DATA_OUT in the SYSTEM_CLK domain and buffers each bus word in a small FIFO.
- Unpacks each word into single pixels on a valid/ready stream, tagged with row/column position and frame-start/frame-end markers.
- Sits between the sensor top level and downstream image storage or a test harness.

---
 rtl/pixel_readout_receiver.sv | 177 +++++++++++++++++
 tb/tb_pixel_readout_receiver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_receiver.sv
// Pixel readout bus receiver: samples the array strobe/bus in the system clock domain,
// buffers bus words in a small FIFO and unpacks them into a positioned pixel stream.
module pixel_readout_receiver #(
  parameter int unsigned WIDTH                  = 100,
  parameter int unsigned HEIGHT                 = 100,
  parameter int unsigned OUTPUT_BUS_PIXEL_WIDTH = 10,
  parameter int unsigned BIT_DEPTH              = 10,
  parameter int unsigned FIFO_DEPTH             = 4
) (
  input  logic                                         SYSTEM_CLK,
  input  logic                                         SYSTEM_RESET,
  input  logic                                         DATA_OUT_CLK,
  input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0]  DATA_OUT,
  input  logic                                         CLEAR_ERRORS,
  input  logic                                         PIXEL_READY,
  output logic                                         PIXEL_VALID,
  output logic [BIT_DEPTH-1:0]                         PIXEL_DATA,
  output logic [$clog2(WIDTH)-1:0]                     PIXEL_COL,
  output logic [$clog2(HEIGHT)-1:0]                    PIXEL_ROW,
  output logic                                         FRAME_START,
  output logic                                         FRAME_END,
  output logic                                         OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]                  FIFO_LEVEL
);

  localparam int unsigned BUS_W  = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam int unsigned COL_W  = $clog2(WIDTH);
  localparam int unsigned ROW_W  = $clog2(HEIGHT);
  localparam int unsigned LANE_W = (OUTPUT_BUS_PIXEL_WIDTH > 1) ? $clog2(OUTPUT_BUS_PIXEL_WIDTH) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  // Capture stage and strobe history
  logic             s1_strobe_q;
  logic [BUS_W-1:0] s1_data_q;
  logic             hist_q;

  // FIFO storage and control
  logic [BUS_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] level_q, level_d;
  logic             overflow_q;

  // Unpacker
  state_e               state_q;
  logic [BUS_W-1:0]     word_q;
  logic [LANE_W-1:0]    lane_q;
  logic                 valid_q;
  logic [BIT_DEPTH-1:0] data_q;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;

  logic                 push_c, full_c, empty_c, pop_c, wr_en_c, hs_c, last_lane_c;
  logic [BUS_W-1:0]     head_c;
  logic [BIT_DEPTH-1:0] next_lane_data_c;
  int unsigned          next_lane_idx_c;

  always_comb begin
    push_c           = s1_strobe_q & ~hist_q;
    full_c           = (level_q == CNT_W'(FIFO_DEPTH));
    empty_c          = (level_q == '0);
    hs_c             = valid_q & PIXEL_READY;
    last_lane_c      = (lane_q == LANE_W'(OUTPUT_BUS_PIXEL_WIDTH - 1));
    pop_c            = ~empty_c & ((state_q == ST_IDLE) |
                                   ((state_q == ST_EMIT) & hs_c & last_lane_c));
    wr_en_c          = push_c & (~full_c | pop_c);
    head_c           = mem_q[rd_ptr_q];
    next_lane_idx_c  = 32'(lane_q) + 32'd1;
    next_lane_data_c = BIT_DEPTH'(word_q >> (next_lane_idx_c * BIT_DEPTH));
    level_d          = level_q;
    case ({wr_en_c, pop_c})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Strobe synchronisation: one push per rising edge of the sampled strobe
  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
    if (!SYSTEM_RESET) begin
      s1_strobe_q <= 1'b0;
      s1_data_q   <= '0;
      hist_q      <= 1'b0;
    end else begin
      s1_strobe_q <= DATA_OUT_CLK;
      s1_data_q   <= DATA_OUT;
      hist_q      <= s1_strobe_q;
    end
  end

  // Storage array needs no reset; emptiness is tracked by the pointers and level
  always_ff @(posedge SYSTEM_CLK) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= s1_data_q;
  end

  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
    if (!SYSTEM_RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      // A fresh drop outranks a simultaneous clear
      if (push_c & full_c & ~pop_c) overflow_q <= 1'b1;
      else if (CLEAR_ERRORS)        overflow_q <= 1'b0;
    end
  end

  // Unpacker FSM: walks the lanes of the word register, refilling without a bubble
  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
    if (!SYSTEM_RESET) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty_c) begin
            word_q  <= head_c;
            lane_q  <= '0;
            data_q  <= head_c[BIT_DEPTH-1:0];
            valid_q <= 1'b1;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (hs_c) begin
            if (!last_lane_c) begin
              lane_q <= lane_q + LANE_W'(1);
              data_q <= next_lane_data_c;
            end else if (!empty_c) begin
              word_q <= head_c;
              lane_q <= '0;
              data_q <= head_c[BIT_DEPTH-1:0];
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Raster position of the pixel currently offered
  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
    if (!SYSTEM_RESET) begin
      col_q <= '0;
      row_q <= '0;
    end else if (hs_c) begin
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_q <= '0;
        row_q <= (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  assign PIXEL_VALID = valid_q;
  assign PIXEL_DATA  = data_q;
  assign PIXEL_COL   = col_q;
  assign PIXEL_ROW   = row_q;
  assign OVERFLOW    = overflow_q;
  assign FIFO_LEVEL  = level_q;
  assign FRAME_START = valid_q & (col_q == '0) & (row_q == '0);
  assign FRAME_END   = valid_q & (col_q == COL_W'(WIDTH - 1)) & (row_q == ROW_W'(HEIGHT - 1));

endmodule

// File: tb/tb_pixel_readout_receiver.sv
// Directed bench for pixel_readout_receiver: a scoreboard queue of expected pixels is
// filled as bus words are strobed in and drained by a handshake monitor.
module tb_pixel_readout_receiver;

  localparam int unsigned W   = 100;
  localparam int unsigned H   = 100;
  localparam int unsigned N   = 10;
  localparam int unsigned BD  = 10;
  localparam int unsigned FD  = 4;
  localparam int unsigned BUS = N * BD;

  typedef struct {
    logic [BD-1:0] data;
    logic [6:0]    row;
    logic [6:0]    col;
    logic          fs;
    logic          fe;
  } exp_t;

  logic           clk, rst_n, strobe, clear_errors, ready;
  logic [BUS-1:0] bus;
  logic           pix_valid, frame_start, frame_end, overflow;
  logic [BD-1:0]  pix_data;
  logic [6:0]     pix_col, pix_row;
  logic [2:0]     fifo_level;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   hs_count = 0;
  int   fe_seen = 0;
  int   m_row = 0;
  int   m_col = 0;

  pixel_readout_receiver #(
    .WIDTH(W), .HEIGHT(H), .OUTPUT_BUS_PIXEL_WIDTH(N), .BIT_DEPTH(BD), .FIFO_DEPTH(FD)
  ) dut (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rst_n), .DATA_OUT_CLK(strobe), .DATA_OUT(bus),
    .CLEAR_ERRORS(clear_errors), .PIXEL_READY(ready), .PIXEL_VALID(pix_valid),
    .PIXEL_DATA(pix_data), .PIXEL_COL(pix_col), .PIXEL_ROW(pix_row),
    .FRAME_START(frame_start), .FRAME_END(frame_end), .OVERFLOW(overflow),
    .FIFO_LEVEL(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BUS-1:0] mk(input int base);
    logic [BUS-1:0] w;
    w = '0;
    for (int l = 0; l < int'(N); l++) w[l*BD +: BD] = BD'(base + l);
    return w;
  endfunction

  task automatic model_push(input logic [BUS-1:0] w);
    exp_t e;
    for (int l = 0; l < int'(N); l++) begin
      e.data = w[l*BD +: BD];
      e.row  = 7'(m_row);
      e.col  = 7'(m_col);
      e.fs   = (m_row == 0) && (m_col == 0);
      e.fe   = (m_row == int'(H) - 1) && (m_col == int'(W) - 1);
      q.push_back(e);
      if (m_col == int'(W) - 1) begin
        m_col = 0;
        m_row = (m_row == int'(H) - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
  endtask

  task automatic send_word(input logic [BUS-1:0] w, input bit keep);
    bus    = w;
    strobe = 1'b1;
    if (keep) model_push(w);
    tick;
    strobe = 1'b0;
    tick;
  endtask

  task automatic drain(input int max_cycles, input string tag);
    int c;
    c = 0;
    while (q.size() != 0 && c < max_cycles) begin
      tick;
      c++;
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic model_reset;
    q.delete();
    m_row = 0;
    m_col = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    model_reset();
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Scoreboard side: every accepted pixel must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && pix_valid && ready) begin
      hs_count++;
      if (frame_end) fe_seen++;
      chk("pix_expected_present", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("pix_data", 32'(pix_data), 32'(mon_e.data));
        chk("pix_row", 32'(pix_row), 32'(mon_e.row));
        chk("pix_col", 32'(pix_col), 32'(mon_e.col));
        chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
        chk("frame_end", 32'(frame_end), 32'(mon_e.fe));
      end
    end
  end

  initial begin
    int          peak;
    int          cyc;
    int          n;
    logic [BD-1:0] held;

    rst_n = 1'b0; strobe = 1'b0; bus = '0; clear_errors = 1'b0; ready = 1'b0;

    // Reset with the strobe toggling
    for (int i = 0; i < 8; i++) begin
      bus    = mk(100 + i);
      strobe = ~strobe;
      tick;
    end
    strobe = 1'b0;
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_col", 32'(pix_col), 32'd0);
    chk("rst_row", 32'(pix_row), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_fe", 32'(frame_end), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick;

    // First word: capture latency then ten consecutive pixels
    bus    = mk(1);
    strobe = 1'b1;
    model_push(bus);
    tick;
    chk("lat_level_c1", 32'(fifo_level), 32'd0);
    strobe = 1'b0;
    tick;
    chk("lat_level_c2", 32'(fifo_level), 32'd1);
    tick;
    for (int i = 0; i < int'(N); i++) begin
      chk("first_consec_valid", 32'(pix_valid), 32'd1);
      tick;
    end
    chk("first_valid_drop", 32'(pix_valid), 32'd0);
    chk("first_sb_empty", 32'(q.size()), 32'd0);

    // Full frame, one strobe every 12 cycles
    do_reset();
    fe_seen = 0;
    for (int k = 0; k < int'(W * H / N); k++) begin
      send_word(mk(k * 10), 1'b1);
      repeat (10) tick;
    end
    drain(200, "frame_drain");
    chk("frame_end_count", 32'(fe_seen), 32'd1);
    chk("frame_wrap_col", 32'(pix_col), 32'd0);
    chk("frame_wrap_row", 32'(pix_row), 32'd0);

    // Backpressure: three words arrive while stalled
    ready = 1'b0;
    tick;
    for (int k = 0; k < 3; k++) begin
      send_word(mk(3000 + k * 10), 1'b1);
      repeat (3) tick;
    end
    repeat (35) tick;
    held = q[0].data;
    chk("bp_level", 32'(fifo_level), 32'd2);
    chk("bp_valid", 32'(pix_valid), 32'd1);
    chk("bp_data", 32'(pix_data), 32'(held));
    repeat (3) tick;
    chk("bp_data_held", 32'(pix_data), 32'(held));
    ready = 1'b1;
    drain(100, "bp_drain");

    // Overflow: seven words while stalled, last two dropped
    ready = 1'b0;
    tick;
    for (int k = 0; k < 7; k++) begin
      send_word(mk(4000 + k * 10), k < 5);
      repeat (2) tick;
    end
    repeat (5) tick;
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (3) tick;
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_errors = 1'b1;
    tick;
    clear_errors = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    ready = 1'b1;
    drain(100, "ovf_drain");
    tick;
    chk("ovf_level_empty", 32'(fifo_level), 32'd0);

    // Long strobe: one push only
    bus    = mk(5000);
    strobe = 1'b1;
    model_push(bus);
    peak = 0;
    repeat (20) begin
      tick;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    strobe = 1'b0;
    drain(50, "long_drain");
    repeat (20) tick;
    chk("long_peak", 32'(peak), 32'd1);
    chk("long_idle_valid", 32'(pix_valid), 32'd0);
    chk("long_level", 32'(fifo_level), 32'd0);

    // Mid-frame reset after 537 pixels
    do_reset();
    hs_count = 0;
    cyc = 0;
    n = 0;
    while (hs_count < 537 && cyc < 2000) begin
      if (cyc % 12 == 0) begin
        bus    = mk(6000 + n * 10);
        strobe = 1'b1;
        model_push(bus);
        n++;
      end else if (cyc % 12 == 1) begin
        strobe = 1'b0;
      end
      tick;
      cyc++;
    end
    chk("mid_reached", 32'(hs_count), 32'd537);
    rst_n  = 1'b0;
    strobe = 1'b0;
    model_reset();
    tick;
    tick;
    chk("mid_rst_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_col", 32'(pix_col), 32'd0);
    chk("mid_rst_row", 32'(pix_row), 32'd0);
    rst_n = 1'b1;
    tick;
    send_word(mk(7000), 1'b1);
    drain(50, "mid_drain");
    repeat (20) tick;
    chk("mid_no_stale", 32'(pix_valid), 32'd0);
    chk("mid_final_level", 32'(fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
